// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter.
//   Sends one 5..9 bit character per tx_valid/tx_ready handshake.
//   Frame: start bit, data LSB-first, optional parity bit, 1 or 2 stop bits.
//   The frame format and divisor are sampled at accept, so a frame in
//   flight is unaffected by later configuration changes.
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   tx_en              allow new frames (a frame in flight always completes)
//   parity[1:0]        00 none, 01 odd, 10 even, 11 none
//   data_bits[2:0]     000..100 -> 5..9 bits, 101..111 -> 8 bits
//   stop_bit           0 one stop bit, 1 two stop bits
//   tx_divisor[15:0]   clk cycles per bit (0 behaves as 1)
//   tx_data[8:0]       character; bits above the width are ignored
//   tx_valid/tx_ready  handshake
//   tx                 registered serial line, idle high
//   tx_done            high in the last cycle of the final stop bit
//   tx_idle            no frame in flight
//
// Build option UART_TX_BREAK_EN adds input tx_break: while high in IDLE
// the line is held low and no characters are accepted.
//
// state  | meaning
// IDLE   | line high (or low for break), waiting for a character
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | one or two stop bits (1)

module uart_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic [1:0]  parity,
    input  logic [2:0]  data_bits,
    input  logic        stop_bit,
    input  logic [15:0] tx_divisor,
    input  logic [8:0]  tx_data,
    input  logic        tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic        tx_break,
`endif
    output logic        tx_ready,
    output logic        tx,
    output logic        tx_done,
    output logic        tx_idle
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t      state_q;
    logic [15:0] timer_q;
    logic [15:0] div_q;
    logic [8:0]  shift_q;
    logic [3:0]  bit_idx_q;
    logic [3:0]  nbits_q;
    logic        par_en_q;
    logic        par_bit_q;
    logic        stop2_q;
    logic        stop_sec_q;
    logic        tx_q;

    logic        break_req;
    logic [3:0]  nbits_d;
    logic [8:0]  data_d;
    logic [15:0] div_d;
    logic        accept;
    logic        bit_end;

`ifdef UART_TX_BREAK_EN
    assign break_req = tx_break;
`else
    assign break_req = 1'b0;
`endif

    always_comb begin
        nbits_d = 4'd8;
        data_d  = tx_data;
        case (data_bits)
            3'b000: begin nbits_d = 4'd5; data_d = {4'b0, tx_data[4:0]}; end
            3'b001: begin nbits_d = 4'd6; data_d = {3'b0, tx_data[5:0]}; end
            3'b010: begin nbits_d = 4'd7; data_d = {2'b0, tx_data[6:0]}; end
            3'b100: begin nbits_d = 4'd9; data_d = tx_data;                end
            default: begin nbits_d = 4'd8; data_d = {1'b0, tx_data[7:0]}; end
        endcase
    end

    assign div_d    = (tx_divisor == 16'd0) ? 16'd1 : tx_divisor;
    assign tx_ready = rst_n & (state_q == S_IDLE) & tx_en & ~break_req;
    assign accept   = tx_valid & tx_ready;
    assign bit_end  = (timer_q == 16'd0);
    assign tx_idle  = (state_q == S_IDLE);
    assign tx       = tx_q;
    // Done is decoded from registered state so it lines up with the
    // final stop-bit cycle even when the divisor is 1.
    assign tx_done  = (state_q == S_STOP) & bit_end & (~stop2_q | stop_sec_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            div_q      <= 16'd0;
            shift_q    <= 9'd0;
            bit_idx_q  <= 4'd0;
            nbits_q    <= 4'd0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= ~break_req;
                    if (accept) begin
                        state_q    <= S_START;
                        tx_q       <= 1'b0;
                        timer_q    <= div_d - 16'd1;
                        div_q      <= div_d;
                        shift_q    <= data_d;
                        nbits_q    <= nbits_d;
                        par_en_q   <= (parity == 2'b01) | (parity == 2'b10);
                        // Odd parity is the inverted even parity.
                        par_bit_q  <= (^data_d) ^ (parity == 2'b01);
                        stop2_q    <= stop_bit;
                        stop_sec_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= 4'd0;
                        timer_q   <= div_q - 16'd1;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer_q <= div_q - 16'd1;
                        if (bit_idx_q == nbits_q - 4'd1) begin
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        timer_q <= div_q - 16'd1;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        if (stop2_q && !stop_sec_q) begin
                            stop_sec_q <= 1'b1;
                            timer_q    <= div_q - 16'd1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one 5–9 bit character per handshake into a standard asynchronous frame: start bit, data LSB-first, optional parity bit, and 1 or 2 stop bits. It shares the frame-format encodings and divisor register with the receive path, so both directions of the UART run from the same configuration block. It sits between the TX FIFO (or register interface) and the `tx` pad.

## Interface
- No parameters; all frame format is runtime configuration.
- `clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_en` input 1: enables frame acceptance. When low, no new frame is accepted and a frame in flight completes.
- `parity` input 2: 00 none, 01 odd, 10 even, 11 reserved (treated as none).
- `data_bits` input 3: 000=5, 001=6, 010=7, 011=8, 100=9 bits; 101–111 treated as 8.
- `stop_bit` input 1: 0 = one stop bit, 1 = two stop bits.
- `tx_divisor` input 16: clk cycles per bit period; 0 is treated as 1.
- `tx_data` input 9: character to send; bits above the configured width are ignored.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: block can accept a character.
- `tx` output 1: serial line, registered; idle high.
- `tx_done` output 1: one-cycle pulse when a frame completes.
- `tx_idle` output 1: high when no frame is in flight.

## Operation
- State machine states: IDLE, START, DATA, PARITY, STOP.
- `tx_ready` = (state==IDLE) & `tx_en`. It is combinational from registered state.
- Accept: `tx_valid & tx_ready` in IDLE.
  - Latch `tx_data`, `parity`, `data_bits`, `stop_bit` and `tx_divisor`.
  - Changes to these inputs mid-frame have no effect on the frame in flight.
  - Go to START.
- Bit timer: 16-bit down-counter loaded with divisor−1 at each bit start. A bit ends when the counter reaches 0.
- START: `tx`=0 for one bit period, then go to DATA.
- DATA: send bit index 0..N−1 (N = latched width), one bit per period, LSB first.
  - After bit N−1, go to PARITY if parity is 01 or 10, otherwise go to STOP.
- PARITY: one bit period.
  - Even: bit = XOR of the N data bits.
  - Odd: bit = XNOR of the N data bits.
- STOP: `tx`=1 for 1 bit period, or 2 if `stop_bit` was latched as 1.
  - `tx_done` pulses in the last cycle of the final stop period.
  - Next state is IDLE.
- `tx_idle` = (state==IDLE).
- IDLE drives `tx`=1.
- `tx_valid` asserted while `tx_en`=0: held off; accepted on the first cycle `tx_en` is high in IDLE.
- Deasserting `tx_en` mid-frame: the current frame finishes normally.
- Frame length in clk cycles: D × (1 + N + P + S), where P ∈ {0,1} and S ∈ {1,2}.

## Timing
- Reset values: `tx`=1, `tx_ready`=0 while `rst_n` low (state=IDLE, so `tx_ready`=`tx_en` after release), `tx_done`=0, `tx_idle`=1, state=IDLE, counters 0.
- Reset mid-frame: `tx` goes to 1 asynchronously; the partial frame is abandoned.
- Accept at cycle k → `tx` falls at cycle k+1, and the start bit spans cycles k+1..k+D.
- Each subsequent bit spans exactly D cycles with no gaps between bits.
- `tx_done` is high in the last cycle of the final stop bit. State is IDLE in the next cycle.
- Back-to-back: with `tx_valid` held high, the next accept happens the cycle after `tx_done`. The next start bit begins two cycles after `tx_done`, giving a stop-to-start gap of stop period + 1 cycle.

## Configuration
- `UART_TX_BREAK_EN`
  - Defined: adds input `tx_break` (1 bit).
    - While `tx_break` is high in IDLE, `tx` is driven 0 and `tx_ready`=0.
    - A break requested mid-frame takes effect after `tx_done`.
    - Releasing break returns `tx` to 1 the next cycle.
  - Undefined: no port and no break logic; `tx` is low only during start and 0-valued data/parity bits.

## Test plan
- 8N1, D=4, send 0x0A5: `tx` = 0,1,0,1,0,0,1,0,1,1 (start, data LSB-first, stop), each held 4 cycles; 40 cycles total. `tx_done` pulses at cycle 40 after the falling edge.
- 8E1 and 8O1, D=4, 0x0A5: parity bit 0 (even) and 1 (odd); 44 cycles total.
- 5N2, D=3, data 0x1FF: only bits [4:0]=11111 are sent, followed by 2 stop bits; 24 cycles. Changing `data_bits` mid-frame does not alter the frame.
- 9N1, D=1, data 0x100: start 0, eight 0s, then 1, then stop 1. Back-to-back second frame's start begins exactly 2 cycles after the first `tx_done`.
- `tx_divisor`=0: bits last 1 cycle. Assert `rst_n`=0 mid-DATA: `tx`=1, `tx_idle`=1 immediately, and no `tx_done` pulse.
- `tx_en`=0 with `tx_valid`=1: no transmission and `tx_ready`=0. Raise `tx_en`: start bit on the following cycle.
